// File: rtl/lc3_trace_pkg.sv
// ----------------------------------------------------------------------------
// lc3_trace_pkg : shared types and helpers for the LC3 pipeline trace capture
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lc3_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_READ  = 2'd3
   } trace_state_e;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int sel_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   // Out-of-range selects (non power-of-2 CHANNELS) fall back to the top channel.
   function automatic int chan_lsb(input int ch, input int channels, input int width);
      return ((ch < channels) ? ch : channels - 1) * width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_trace_ram.sv
// ----------------------------------------------------------------------------
// lc3_trace_ram : DEPTH x DW simple dual-port buffer, registered read port
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lc3_trace_ram
   import lc3_trace_pkg::*;
#(
   parameter  int DEPTH = 64,
   parameter  int DW    = 64,
   localparam int AW    = addr_width(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Only the output register is reset; the storage array never is.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/lc3_trace_capture.sv
// ----------------------------------------------------------------------------
// lc3_trace_capture : triggered circular probe capture with oldest-first readout
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lc3_trace_capture
   import lc3_trace_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 16,
   parameter  int DEPTH    = 64,
   localparam int AW       = addr_width(DEPTH),
   localparam int TW       = sel_width(CHANNELS),
   localparam int DW       = CHANNELS * WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [DW-1:0]    probe_data,
   input  logic             probe_valid,
   input  logic             arm,
   input  logic [TW-1:0]    trig_channel,
   input  logic [WIDTH-1:0] trig_value,
   input  logic [WIDTH-1:0] trig_mask,
   input  logic [AW:0]      post_count,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [DW-1:0]    rd_data,
   output logic             rd_last,
   output logic             busy,
   output logic             triggered
);

   localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   L_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   L_TWO  = (AW+1)'(2);
   localparam logic [AW-1:0] PMAX   = AW'(DEPTH - 1);
   localparam logic [AW-1:0] P_ONE  = AW'(1);

   trace_state_e  state_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, post_left_q;
   logic [AW:0]   fill_q, left_q;
   logic          triggered_q, rd_valid_q, rd_last_q, prime_q;

   logic [AW-1:0]    wr_ptr_d, rd_start_d, post_clamp;
   logic [AW:0]      fill_d;
   logic [WIDTH-1:0] trig_ch;
   logic             wr_en, match, hs, rd_en;
   int               trig_lsb;

   assign trig_lsb   = chan_lsb(int'(trig_channel), CHANNELS, WIDTH);
   assign trig_ch    = probe_data[trig_lsb +: WIDTH];
   assign wr_en      = ((state_q == ST_ARMED) || (state_q == ST_POST)) && probe_valid;
   assign match      = (state_q == ST_ARMED) && probe_valid &&
                       (((trig_ch ^ trig_value) & trig_mask) == '0);
   assign post_clamp = (post_count >= FULL) ? PMAX : post_count[AW-1:0];
   assign wr_ptr_d   = wr_ptr_q + P_ONE;
   assign fill_d     = (fill_q == FULL) ? FULL : fill_q + L_ONE;
   // Readout window is computed from the post-write pointer/fill of the final sample.
   assign rd_start_d = (fill_d == FULL) ? wr_ptr_d : '0;
   assign hs         = rd_valid_q && rd_ready;
   assign rd_en      = (state_q == ST_READ) && (prime_q || (hs && !rd_last_q));

   lc3_trace_ram #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_ram (
      .clock   (clock),
      .reset   (reset),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (probe_data),
      .re_i    (rd_en),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         post_left_q <= '0;
         fill_q      <= '0;
         left_q      <= '0;
         triggered_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         prime_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  state_q     <= ST_ARMED;
                  wr_ptr_q    <= '0;
                  fill_q      <= '0;
                  post_left_q <= '0;
               end
            end
            ST_ARMED: begin
               if (wr_en) begin
                  wr_ptr_q <= wr_ptr_d;
                  fill_q   <= fill_d;
                  if (match) begin
                     triggered_q <= 1'b1;
                     post_left_q <= post_clamp;
                     if (post_clamp == '0) begin
                        state_q  <= ST_READ;
                        rd_ptr_q <= rd_start_d;
                        left_q   <= fill_d;
                        prime_q  <= 1'b1;
                     end else begin
                        state_q <= ST_POST;
                     end
                  end
               end
            end
            ST_POST: begin
               if (wr_en) begin
                  wr_ptr_q    <= wr_ptr_d;
                  fill_q      <= fill_d;
                  post_left_q <= post_left_q - P_ONE;
                  if (post_left_q == P_ONE) begin
                     state_q  <= ST_READ;
                     rd_ptr_q <= rd_start_d;
                     left_q   <= fill_d;
                     prime_q  <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               // left_q counts the words still to be presented, including the current one.
               if (prime_q) begin
                  prime_q    <= 1'b0;
                  rd_valid_q <= 1'b1;
                  rd_last_q  <= (left_q == L_ONE);
                  rd_ptr_q   <= rd_ptr_q + P_ONE;
               end else if (hs) begin
                  if (rd_last_q) begin
                     state_q     <= ST_IDLE;
                     rd_valid_q  <= 1'b0;
                     rd_last_q   <= 1'b0;
                     triggered_q <= 1'b0;
                  end else begin
                     left_q    <= left_q - L_ONE;
                     rd_last_q <= (left_q == L_TWO);
                     rd_ptr_q  <= rd_ptr_q + P_ONE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign busy      = (state_q != ST_IDLE);
   assign triggered = triggered_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_trace_capture.sv
// ----------------------------------------------------------------------------
// tb_lc3_trace_capture : directed scoreboard bench for lc3_trace_capture
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lc3_trace_capture;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] probe_data;
   logic        probe_valid;
   logic        arm;
   logic [1:0]  trig_channel;
   logic [15:0] trig_value;
   logic [15:0] trig_mask;
   logic [6:0]  post_count;
   logic        rd_valid;
   logic        rd_ready;
   logic [63:0] rd_data;
   logic        rd_last;
   logic        busy;
   logic        triggered;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic bp_mode = 1'b0;

   lc3_trace_capture #(
      .CHANNELS (4),
      .WIDTH    (16),
      .DEPTH    (64)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .probe_data   (probe_data),
      .probe_valid  (probe_valid),
      .arm          (arm),
      .trig_channel (trig_channel),
      .trig_value   (trig_value),
      .trig_mask    (trig_mask),
      .post_count   (post_count),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .rd_last      (rd_last),
      .busy         (busy),
      .triggered    (triggered)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] mk(input logic [15:0] c0, input logic [15:0] c2);
      return {c0 ^ 16'hD00D, c2, ~c0, c0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] c0, input logic [15:0] c2);
      probe_valid = v;
      probe_data  = mk(c0, c2);
      tick();
   endtask

   task automatic push(input logic [15:0] c0, input logic [15:0] c2, input logic last);
      exp_q.push_back('{mk(c0, c2), last});
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check({name, "_busy_end"}, busy, 0);
      check({name, "_valid_end"}, rd_valid, 0);
      check({name, "_trig_end"}, triggered, 0);
      check({name, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Ready driver: held high, or toggled every cycle when backpressure is on.
   initial begin
      rd_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         rd_ready = bp_mode ? ~rd_ready : 1'b1;
      end
   end

   // Monitor: every accepted word is checked against the head of the scoreboard.
   always @(negedge clock) begin
      if (reset && rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word actual=%h required=none", rd_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd_data", rd_data, e.data);
            check("rd_last", {63'b0, rd_last}, {63'b0, e.last});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset        = 1'b0;
      arm          = 1'b0;
      probe_valid  = 1'b0;
      probe_data   = '0;
      trig_channel = 2'd0;
      trig_value   = '0;
      trig_mask    = '0;
      post_count   = '0;
      repeat (3) tick();
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_busy", busy, 0);
      check("rst_triggered", triggered, 0);
      check("rst_rd_data", rd_data, 64'h0);
      reset = 1'b1;
      tick();

      // Basic window: 10 pre samples, trigger on 9, 3 post samples.
      trig_value = 16'd9; trig_mask = 16'hFFFF; post_count = 7'd3;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check("a_busy_after_arm", busy, 1);
      for (int k = 0; k <= 12; k++) begin
         push(16'(k), 16'h0, k == 12);
         drive(1'b1, 16'(k), 16'h0);
         if (k == 8) check("a_not_trig_yet", triggered, 0);
         if (k == 9) check("a_triggered", triggered, 1);
      end
      probe_valid = 1'b0;
      wait_idle("a", 100);

      // Wrap: 100 samples, trigger on the last with no post window.
      trig_value = 16'd99; post_count = 7'd0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (k >= 36) push(16'(k), 16'h0, k == 99);
         drive(1'b1, 16'(k), 16'h0);
      end
      probe_data = mk(16'hEEEE, 16'h0);
      check("b_valid_t1", rd_valid, 0);
      tick();
      check("b_valid_t2", rd_valid, 1);
      check("b_first_word", rd_data[15:0], 64'd36);
      wait_idle("b", 200);
      probe_valid = 1'b0;

      // Masked trigger on channel 2 (ADD opcode), with invalid gaps.
      trig_channel = 2'd2; trig_value = 16'h1000; trig_mask = 16'hF000; post_count = 7'd2;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      push(16'd1, 16'h5123, 1'b0); drive(1'b1, 16'd1, 16'h5123);
      drive(1'b0, 16'd90, 16'h1000);
      push(16'd2, 16'h5FFF, 1'b0); drive(1'b1, 16'd2, 16'h5FFF);
      push(16'd3, 16'h2000, 1'b0); drive(1'b1, 16'd3, 16'h2000);
      drive(1'b0, 16'd91, 16'h1111);
      check("c_no_trig", triggered, 0);
      push(16'd4, 16'h1A3F, 1'b0); drive(1'b1, 16'd4, 16'h1A3F);
      check("c_trig", triggered, 1);
      drive(1'b0, 16'd92, 16'h1000);
      push(16'd5, 16'h1000, 1'b0); drive(1'b1, 16'd5, 16'h1000);
      drive(1'b0, 16'd93, 16'h1000);
      push(16'd6, 16'h1001, 1'b1); drive(1'b1, 16'd6, 16'h1001);
      probe_valid = 1'b0;
      wait_idle("c", 100);

      // Clamp: 200 truncates to 72 on the 7-bit port, still above 63; mask 0
      // triggers on the first valid sample. Backpressure and arm during READ.
      trig_channel = 2'd0; trig_mask = 16'h0000; post_count = 7'(200);
      bp_mode = 1'b1;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      drive(1'b0, 16'd7, 16'h0);
      for (int k = 0; k < 64; k++) begin
         push(16'(500 + k), 16'h0, k == 63);
         drive(1'b1, 16'(500 + k), 16'h0);
         if (k == 0) check("d_trig_first", triggered, 1);
      end
      arm = 1'b1;
      for (int k = 0; k < 4; k++) drive(1'b1, 16'hBEEF, 16'h0);
      arm = 1'b0;
      check("d_busy_in_read", busy, 1);
      check("d_trig_in_read", triggered, 1);
      wait_idle("d", 400);
      probe_valid = 1'b0;
      bp_mode = 1'b0;

      // Reset mid-POST, then a clean restart.
      trig_value = 16'd0; trig_mask = 16'hFFFF; post_count = 7'd10;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int k = 0; k < 4; k++) drive(1'b1, 16'(k), 16'h0);
      check("e_trig_before_rst", triggered, 1);
      reset = 1'b0;
      probe_valid = 1'b0;
      tick();
      check("e_rst_busy", busy, 0);
      check("e_rst_trig", triggered, 0);
      check("e_rst_valid", rd_valid, 0);
      reset = 1'b1;
      trig_value = 16'd7; post_count = 7'd1;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check("e_rearm_busy", busy, 1);
      push(16'd7, 16'h0, 1'b0); drive(1'b1, 16'd7, 16'h0);
      push(16'd8, 16'h0, 1'b1); drive(1'b1, 16'd8, 16'h0);
      probe_valid = 1'b0;
      wait_idle("e", 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lc3_trace_capture.md
# lc3_trace_capture

Synthesizable, parametrised probe-capture block for the LC3 pipeline: it samples CHANNELS probe words per cycle into a circular buffer, triggers on a masked match on one selectable channel, captures a programmable post-trigger window, then streams the window out oldest-first over a valid/ready port. It sits beside the LC3 core and observes the same stage signals the bench probes do (IR, IR_Exec, NZP, pc, bypass flags), giving on-silicon visibility of pipeline history around an event.

## Interface
- CHANNELS, 4, number of probe channels sampled per cycle
- WIDTH, 16, bits per channel
- DEPTH, 64, buffer entries (power of 2, ≥4); AW = $clog2(DEPTH)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- probe_data  in  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]
- probe_valid  in  1  sample qualifier; only valid cycles are stored/matched
- arm  in  1  start capture; honoured only in IDLE
- trig_channel  in  max(1,$clog2(CHANNELS))  channel compared for trigger
- trig_value  in  WIDTH  match value
- trig_mask  in  WIDTH  1 = bit compared; all-zero mask = trigger on first valid sample
- post_count  in  AW+1  samples stored after trigger sample; clamped to DEPTH-1
- rd_valid  out  1  readout word available
- rd_ready  in  1  consumer accepts word
- rd_data  out  CHANNELS*WIDTH  captured sample
- rd_last  out  1  qualifies final word of window
- busy  out  1  state != IDLE
- triggered  out  1  trigger seen this capture; cleared on return to IDLE

## Operation
- States: IDLE, ARMED, POST, READ.
- IDLE: arm=1 → ARMED next cycle; wr_ptr, fill, post counters cleared on that transition. Inputs sampled in the arm cycle are not stored.
- ARMED: each probe_valid cycle writes mem[wr_ptr], wr_ptr+1 mod DEPTH, fill saturates at DEPTH. Match = probe_valid && ((ch[trig_channel] ^ trig_value) & trig_mask)==0; matching sample is stored, triggered←1, post_left←min(post_count,DEPTH-1) latched. If post_left==0 → READ, else → POST.
- POST: valid samples written as in ARMED; post_left decremented per write; the write making it 0 moves to READ. Trigger matches ignored. Since post_left ≤ DEPTH-1, the trigger sample is never overwritten.
- READ: count = fill (≤DEPTH); start = (fill==DEPTH) ? wr_ptr : 0. rd_data is a registered read of mem[rd_ptr]. On rd_valid && rd_ready: rd_ptr+1 mod DEPTH, remaining−1; if rd_last → IDLE. probe inputs ignored.
- arm outside IDLE ignored. trig_* and post_count sampled only at the trigger cycle.
- Reset mid-operation: state → IDLE from any state; buffer contents not cleared, not readable.

## Timing
- Reset values: rd_valid=0, rd_last=0, busy=0, triggered=0, rd_data=0.
- arm at cycle t → busy=1 at t+1, first storable sample at t+1.
- Trigger sample at cycle t (post_count=0) → rd_valid=1 at t+2 (one cycle for state entry, one for registered read); rd_data = oldest sample.
- Full throughput: a new word each cycle while rd_ready held high; next word pre-read on handshake cycle.
- rd_valid/rd_data/rd_last stable while rd_valid && !rd_ready.
- After final handshake at cycle t: rd_valid=0, busy=0, triggered=0 at t+1; arm accepted at t+1.

## Structure
- Package lc3_trace_pkg: state enum (IDLE, ARMED, POST, READ), AW helper function, channel-select function.
- One sub-module lc3_trace_ram: simple dual-port DEPTH×(CHANNELS*WIDTH), one write port, registered read port, no reset on storage.

## Test plan
- Reset mid-POST (reset=0 one cycle) → busy=0, triggered=0, rd_valid=0 next cycle; arm then restarts cleanly.
- DEPTH=64, arm, 10 valid samples ch0=0..9, trigger value 9 mask 16'hFFFF, post_count=3, then ch0=10..12 → 13 words out 0..12, rd_last on 12.
- Wrap: 100 pre-trigger samples ch0=0..99, trigger at 99, post_count=0 → 64 words 36..99, rd_last on 99.
- Masked trigger on trig_channel=2, value 16'h1000 mask 16'hF000 (opcode ADD on IR channel): ch2=16'h5xxx no trigger, ch2=16'h1A3F triggers; gaps with probe_valid=0 not stored.
- post_count=200 → clamped to 63; trigger sample remains first word.
- Backpressure: rd_ready toggled 1/0 each cycle → each word presented until accepted, no loss/duplication; arm asserted during READ ignored.
